// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a NUM_LANES-input select mux: grants one lane,
// holds sel for SETTLE_CYCLES, captures mux data and offers it on a valid/ready port.
module mux_rr_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 5
) (
  input  logic             req_i,
  input  logic             mask_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             elig_o,
  output logic             elig_hi_o
);
  localparam logic [SEL_W-1:0] IDX_V = SEL_W'(IDX);

  assign elig_o    = req_i & ~mask_i;
  assign elig_hi_o = elig_o & (IDX_V > ptr_i);
endmodule

module mux_rr_scheduler #(
  parameter int NUM_LANES     = 31,
  parameter int SEL_W         = 5,
  parameter int DATA_W        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [NUM_LANES-1:0] mask_i,
  input  logic [DATA_W-1:0]    mux_out_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [DATA_W-1:0]    out_data_o,
  output logic [SEL_W-1:0]     out_lane_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  lane;
    logic              valid;
  } out_t;

  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_LANES - 1);
  localparam logic [3:0]       SETTLE_V = 4'(SETTLE_CYCLES);

  state_t               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     ptr_q;
  logic [3:0]           cnt_q;
  logic [NUM_LANES-1:0] gnt_q;
  logic                 busy_q;
  out_t                 out_q;

  logic [NUM_LANES-1:0] elig, elig_hi;
  logic [SEL_W-1:0]     hi_idx, lo_idx, pick_d;
  logic                 hi_vld, pick_vld;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mux_rr_lane #(.IDX(g), .SEL_W(SEL_W)) u_lane (
      .req_i     (req_i[g]),
      .mask_i    (mask_i[g]),
      .ptr_i     (ptr_q),
      .elig_o    (elig[g]),
      .elig_hi_o (elig_hi[g])
    );
  end

  // Lanes above the pointer win; otherwise wrap to the lowest eligible lane,
  // which leaves the pointer lane itself as the last choice.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (elig_hi[i]) begin
        hi_idx = SEL_W'(i);
        hi_vld = 1'b1;
      end
      if (elig[i]) lo_idx = SEL_W'(i);
    end
    pick_vld = |elig;
    pick_d   = hi_vld ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (en_i && pick_vld) begin
            sel_q   <= pick_d;
            cnt_q   <= SETTLE_V;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_q.data  <= mux_out_i;
            out_q.lane  <= sel_q;
            out_q.valid <= 1'b1;
            gnt_q       <= NUM_LANES'(1) << sel_q;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_q.valid && out_ready_i) begin
            out_q.valid <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= out_q.lane;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign out_data_o  = out_q.data;
  assign out_lane_o  = out_q.lane;
  assign out_valid_o = out_q.valid;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench: SETTLE_CYCLES=1 instance for most scenarios, a SETTLE_CYCLES=3
// instance for the wrap and long-settle case. A table stands in for the mux.
module tb_mux_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst, en, ready, ready2;
  logic [30:0] req, mask, req2;
  logic [4:0]  sel, olane, sel2, olane2;
  logic [30:0] gnt, gnt2;
  logic [1:0]  odata, odata2, mux_out, mux_out2;
  logic        ovalid, busy, ovalid2, busy2;
  logic [1:0]  mux_tbl [0:31];
  int          total = 0;
  int          bad   = 0;
  int          exp_l [0:4];
  int          exp_d [0:4];

  always #5 clk = ~clk;

  assign mux_out  = mux_tbl[sel];
  assign mux_out2 = mux_tbl[sel2];

  mux_rr_scheduler #(.SETTLE_CYCLES(1)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .req_i(req), .mask_i(mask),
    .mux_out_i(mux_out), .sel_o(sel), .gnt_o(gnt), .out_data_o(odata),
    .out_lane_o(olane), .out_valid_o(ovalid), .out_ready_i(ready), .busy_o(busy)
  );

  mux_rr_scheduler #(.SETTLE_CYCLES(3)) dut3 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .req_i(req2), .mask_i(31'd0),
    .mux_out_i(mux_out2), .sel_o(sel2), .gnt_o(gnt2), .out_data_o(odata2),
    .out_lane_o(olane2), .out_valid_o(ovalid2), .out_ready_i(ready2), .busy_o(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mux_tbl[i] = 2'd0;
    mux_tbl[0] = 2'd1; mux_tbl[1] = 2'd3; mux_tbl[3] = 2'd3; mux_tbl[5] = 2'd2;
    mux_tbl[7] = 2'd1; mux_tbl[29] = 2'd2; mux_tbl[30] = 2'd2;
    exp_l = '{0, 3, 30, 0, 3};
    exp_d = '{1, 3, 2, 1, 3};
    rst = 1'b1; en = 1'b0; req = '0; mask = '0; ready = 1'b0; req2 = '0; ready2 = 1'b0;
    step(); step();
    check("rst_sel", sel, 0);       check("rst_gnt", gnt, 0);
    check("rst_data", odata, 0);    check("rst_lane", olane, 0);
    check("rst_valid", ovalid, 0);  check("rst_busy", busy, 0);
    check("rst_valid3", ovalid2, 0);
    rst = 1'b0; en = 1'b1;

    // T1: single request, first grant from the reset pointer
    req = 31'd1 << 5; ready = 1'b1;
    step();
    check("t1_sel", sel, 5); check("t1_busy", busy, 1); check("t1_valid0", ovalid, 0);
    req = '0;
    step();
    check("t1_valid", ovalid, 1); check("t1_data", odata, 2);
    check("t1_lane", olane, 5);   check("t1_gnt", gnt, 31'd1 << 5);
    step();
    check("t1_valid_clr", ovalid, 0); check("t1_gnt_clr", gnt, 0);
    check("t1_busy_clr", busy, 0);    check("t1_sel_hold", sel, 5);

    // T2: round robin over lanes 0,3,30 from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    req = (31'd1 << 0) | (31'd1 << 3) | (31'd1 << 30);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_sel", sel, exp_l[k]);
      if (k == 4) req = '0;
      step();
      check("t2_valid", ovalid, 1); check("t2_lane", olane, exp_l[k]);
      check("t2_data", odata, exp_d[k]);
      step();
      check("t2_idle", ovalid, 0);
    end

    // T3: back-pressure holds everything stable
    req = 31'd1 << 7; ready = 1'b0;
    step();
    check("t3_sel", sel, 7);
    req = '0;
    step();
    check("t3_valid", ovalid, 1); check("t3_data", odata, 1); check("t3_gnt", gnt, 31'd1 << 7);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_hold_valid", ovalid, 1); check("t3_hold_data", odata, 1);
      check("t3_hold_sel", sel, 7);      check("t3_hold_gnt", gnt, 0);
    end
    ready = 1'b1;
    step();
    check("t3_done", ovalid, 0); check("t3_busy", busy, 0);

    // T4: masked lane skipped, en=0 blocks grants, unmasked lane then wins after 7
    req = (31'd1 << 3) | (31'd1 << 7); mask = 31'd1 << 3;
    step();
    check("t4_sel", sel, 7);
    step();
    check("t4_lane", olane, 7);
    en = 1'b0;
    step();
    check("t4_idle", ovalid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_en0_busy", busy, 0); check("t4_en0_valid", ovalid, 0);
    end
    en = 1'b1; mask = '0;
    step();
    check("t4_sel_wrap", sel, 3);
    req = '0;
    step();
    check("t4_lane3", olane, 3); check("t4_data3", odata, 3);
    step();
    check("t4_done", ovalid, 0);

    // T5: move pointer to 0, start lane 1, reset in HOLD
    req = 31'd1;
    step(); check("t5_sel0", sel, 0);
    step(); check("t5_lane0", olane, 0);
    req = 31'd1 << 1;
    step(); check("t5_idle", ovalid, 0);
    ready = 1'b0;
    step(); check("t5_sel1", sel, 1);
    req = '0;
    step(); check("t5_hold", ovalid, 1); check("t5_lane1", olane, 1);
    #3 rst = 1'b1;
    #1;
    check("t5_async_sel", sel, 0);     check("t5_async_gnt", gnt, 0);
    check("t5_async_data", odata, 0);  check("t5_async_lane", olane, 0);
    check("t5_async_valid", ovalid, 0); check("t5_async_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 31'd3; ready = 1'b1;
    step(); check("t5_first", sel, 0); check("t5_first_busy", busy, 1);
    req = '0;
    step(); check("t5_lane", olane, 0); check("t5_gnt", gnt, 31'd1);
    step(); check("t5_done", ovalid, 0);

    // T6: three-cycle settle, wrap from pointer 30 to lane 0 ahead of 29
    req2 = (31'd1 << 0) | (31'd1 << 29); ready2 = 1'b1;
    step(); check("t6_sel", sel2, 0); check("t6_busy", busy2, 1);
    step(); check("t6_settle1", ovalid2, 0);
    step(); check("t6_settle2", ovalid2, 0);
    step();
    check("t6_valid", ovalid2, 1); check("t6_lane", olane2, 0);
    check("t6_data", odata2, 1);   check("t6_gnt", gnt2, 31'd1);
    step(); check("t6_idle", ovalid2, 0);
    step(); check("t6_sel29", sel2, 29);
    req2 = '0;
    step(); step(); step();
    check("t6_valid29", ovalid2, 1); check("t6_lane29", olane2, 29); check("t6_data29", odata2, 2);
    step(); check("t6_done", ovalid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
